// File: rtl/sd_dma_ctrl_pkg.sv
// Shared types and constants for the SD DMA multi-block sequencer.
// The per-block configuration rule lives here so the read-side DMA can reuse it.
package sd_dma_ctrl_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ARM, ST_XFER} state_t;

    localparam int BLOCK_NIBBLES  = 1024;
    localparam int EN_TIMEOUT_DEF = 15;

    typedef struct packed {
        logic        partial;
        logic [10:0] pstart;
        logic [10:0] pend;
        logic        start_mid;
        logic        end_mid;
    } blk_cfg_t;

    // rem == total marks the first block, rem == 1 the last; one block can be both.
    function automatic blk_cfg_t blk_cfg(input logic [15:0] rem, input logic [15:0] total,
                                         input logic [10:0] first_start, input logic [10:0] last_end,
                                         input logic mid_start, input logic mid_end);
        blk_cfg_t c;
        logic     is_first;
        logic     is_last;
        is_first    = (rem == total);
        is_last     = (rem == 16'd1);
        c.pstart    = is_first ? first_start : 11'd0;
        c.pend      = is_last ? last_end : 11'(BLOCK_NIBBLES);
        c.partial   = (c.pstart != 11'd0) || (c.pend != 11'(BLOCK_NIBBLES));
        c.start_mid = is_first & mid_start;
        c.end_mid   = is_last & mid_end;
        return c;
    endfunction

endpackage

// File: rtl/sd_dma_ctrl_if.sv
// Command (MCU register side) and datapath signals of the SD DMA sequencer.
// master = the sequencer, slave = the MCU registers plus the nibble datapath.
interface sd_dma_ctrl_if #(parameter int ADDR_W = 24);
    logic              cmd_start;
    logic              cmd_abort;
    logic [15:0]       blk_count;
    logic [10:0]       first_start;
    logic [10:0]       last_end;
    logic              mid_start;
    logic              mid_end;
    logic [ADDR_W-1:0] addr_base;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       blk_remain;
    logic              sd_dma_en;
    logic              sd_dma_status;
    logic              sd_dma_nextaddr;
    logic              sd_dma_partial;
    logic [10:0]       sd_dma_partial_start;
    logic [10:0]       sd_dma_partial_end;
    logic              sd_dma_start_mid_block;
    logic              sd_dma_end_mid_block;
    logic [ADDR_W-1:0] sram_addr;

    modport master (
        input  cmd_start, cmd_abort, blk_count, first_start, last_end, mid_start, mid_end,
               addr_base, sd_dma_status, sd_dma_nextaddr,
        output busy, done, err, blk_remain, sd_dma_en, sd_dma_partial, sd_dma_partial_start,
               sd_dma_partial_end, sd_dma_start_mid_block, sd_dma_end_mid_block, sram_addr
    );

    modport slave (
        output cmd_start, cmd_abort, blk_count, first_start, last_end, mid_start, mid_end,
               addr_base, sd_dma_status, sd_dma_nextaddr,
        input  busy, done, err, blk_remain, sd_dma_en, sd_dma_partial, sd_dma_partial_start,
               sd_dma_partial_end, sd_dma_start_mid_block, sd_dma_end_mid_block, sram_addr
    );
endinterface

// File: rtl/sd_dma_ctrl_addrgen.sv
// SRAM address counter: load on command start, +1 per strobe, wraps at 2^ADDR_W.
module sd_dma_addrgen #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       addr <= '0;
        else if (load) addr <= load_val;
        else if (inc)  addr <= addr + ADDR_W'(1);
    end

endmodule

// File: rtl/sd_dma_ctrl.sv
// Multi-block SD DMA sequencer: one enable pulse per 512-byte block, per-block
// partial/mid-block config, and ownership of the SRAM write address.
module sd_dma_ctrl
    import sd_dma_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int EN_TIMEOUT = EN_TIMEOUT_DEF
) (
    input logic            clk,
    input logic            rst,
    sd_dma_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(EN_TIMEOUT + 1);

    state_t           state, state_n;
    logic [15:0]      total, total_n, rem, rem_n, rem_dec;
    logic [10:0]      fs_r, fs_n, le_r, le_n;
    logic             ms_r, ms_n, me_r, me_n;
    logic             abort_r, abort_n, abort_pend;
    logic             en, en_n, done, done_n, err, err_n;
    logic [CNT_W-1:0] tmo, tmo_n;
    blk_cfg_t         cfg, cfg_n;
    logic             load, busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            total   <= '0;
            rem     <= '0;
            fs_r    <= '0;
            le_r    <= '0;
            ms_r    <= 1'b0;
            me_r    <= 1'b0;
            abort_r <= 1'b0;
            en      <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            tmo     <= '0;
            cfg     <= '0;
        end else begin
            state   <= state_n;
            total   <= total_n;
            rem     <= rem_n;
            fs_r    <= fs_n;
            le_r    <= le_n;
            ms_r    <= ms_n;
            me_r    <= me_n;
            abort_r <= abort_n;
            en      <= en_n;
            done    <= done_n;
            err     <= err_n;
            tmo     <= tmo_n;
            cfg     <= cfg_n;
        end
    end

    // Config is loaded on the edge that enters SETUP so it leads the EN rise by a cycle.
    always_comb begin
        state_n    = state;
        total_n    = total;
        rem_n      = rem;
        fs_n       = fs_r;
        le_n       = le_r;
        ms_n       = ms_r;
        me_n       = me_r;
        en_n       = en;
        done_n     = 1'b0;
        err_n      = err;
        tmo_n      = tmo;
        cfg_n      = cfg;
        load       = 1'b0;
        rem_dec    = rem - 16'd1;
        abort_pend = abort_r | bus.cmd_abort;
        abort_n    = abort_pend;
        case (state)
            ST_IDLE: begin
                abort_n = 1'b0;
                if (bus.cmd_start) begin
                    err_n = 1'b0;
                    if (bus.blk_count == 16'd0) begin
                        done_n = 1'b1;
                    end else if (bus.blk_count == 16'd1 && bus.first_start > bus.last_end) begin
                        err_n  = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        total_n = bus.blk_count;
                        rem_n   = bus.blk_count;
                        fs_n    = bus.first_start;
                        le_n    = bus.last_end;
                        ms_n    = bus.mid_start;
                        me_n    = bus.mid_end;
                        load    = 1'b1;
                        cfg_n   = blk_cfg(bus.blk_count, bus.blk_count, bus.first_start,
                                          bus.last_end, bus.mid_start, bus.mid_end);
                        state_n = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                en_n    = 1'b1;
                tmo_n   = '0;
                state_n = ST_ARM;
            end
            ST_ARM: begin
                if (bus.sd_dma_status) begin
                    en_n    = 1'b0;
                    state_n = ST_XFER;
                end else if (tmo == CNT_W'(EN_TIMEOUT - 1)) begin
                    en_n    = 1'b0;
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    tmo_n = tmo + CNT_W'(1);
                end
            end
            ST_XFER: begin
                if (!bus.sd_dma_status) begin
                    rem_n = rem_dec;
                    if (rem_dec == 16'd0 || abort_pend) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        cfg_n   = blk_cfg(rem_dec, total, fs_r, le_r, ms_r, me_r);
                        state_n = ST_SETUP;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    sd_dma_addrgen #(.ADDR_W(ADDR_W)) u_addrgen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (bus.addr_base),
        .inc      (bus.sd_dma_nextaddr & busy),
        .addr     (bus.sram_addr)
    );

    assign bus.busy                   = busy;
    assign bus.done                   = done;
    assign bus.err                    = err;
    assign bus.blk_remain             = rem;
    assign bus.sd_dma_en              = en;
    assign bus.sd_dma_partial         = cfg.partial;
    assign bus.sd_dma_partial_start   = cfg.pstart;
    assign bus.sd_dma_partial_end     = cfg.pend;
    assign bus.sd_dma_start_mid_block = cfg.start_mid;
    assign bus.sd_dma_end_mid_block   = cfg.end_mid;

endmodule

// File: tb/tb_sd_dma_ctrl.sv
// Scoreboard bench for sd_dma_ctrl with a behavioural nibble-datapath model.
module tb_sd_dma_ctrl;

    typedef struct {
        logic        partial;
        logic [10:0] ps;
        logic [10:0] pe;
        logic        sm;
        logic        em;
    } cfg_t;

    typedef struct {
        int rem;
        int err;
        int addr;
        int n_en;
        int busy_seen;
        int lat_cmd;
        int lat_en;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dp_status = 1'b0, dp_nxt = 1'b0, idle_nxt = 1'b0, dp_stall = 1'b0;
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, cmd_cyc = 0, en_cyc = 0, en_rises = 0, n_done = 0, busy_seen = 0;
    cfg_t  cfg_q[$];
    done_t done_q[$];

    sd_dma_ctrl_if #(.ADDR_W(24)) bus ();

    sd_dma_ctrl #(.ADDR_W(24), .EN_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.sd_dma_status   = dp_status;
    assign bus.sd_dma_nextaddr = dp_nxt | idle_nxt;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bench-side block plan: block b of cnt is first when b==0, last when b==cnt-1.
    task automatic push_cfgs(input int cnt, input int nblk, input int fs, input int le,
                             input logic ms, input logic me);
        cfg_t c;
        for (int b = 0; b < nblk; b++) begin
            c.ps      = (b == 0) ? 11'(fs) : 11'd0;
            c.pe      = (b == cnt - 1) ? 11'(le) : 11'd1024;
            c.partial = (c.ps != 0) || (c.pe != 11'd1024);
            c.sm      = (b == 0) && ms;
            c.em      = (b == cnt - 1) && me;
            cfg_q.push_back(c);
        end
    endtask

    task automatic push_done(input int rem, input int err, input int addr, input int n_en,
                             input int bs, input int lc, input int le);
        done_t d;
        d = '{rem, err, addr, n_en, bs, lc, le};
        done_q.push_back(d);
    endtask

    task automatic send_cmd(input int cnt, input int fs, input int le, input logic ms,
                            input logic me, input int base);
        @(posedge clk); #1;
        bus.blk_count   = 16'(cnt);
        bus.first_start = 11'(fs);
        bus.last_end    = 11'(le);
        bus.mid_start   = ms;
        bus.mid_end     = me;
        bus.addr_base   = 24'(base);
        bus.cmd_start   = 1'b1;
        @(posedge clk); #1;
        bus.cmd_start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        start = n_done;
        for (int i = 0; i < budget && n_done == start; i++) @(posedge clk);
        check(tag, 32'(n_done != start), 32'd1);
    endtask

    // Datapath: STATUS rises 2 cycles after EN, 512 address strobes, then STATUS drops.
    initial begin : dp_model
        forever begin
            @(posedge bus.sd_dma_en);
            if (dp_stall) continue;
            repeat (2) @(posedge clk);
            #1 dp_status = 1'b1;
            dp_nxt = 1'b1;
            repeat (512) @(posedge clk);
            #1 dp_nxt = 1'b0;
            dp_status = 1'b0;
        end
    end

    initial begin : monitor
        logic        en_q, done_prev;
        logic [24:0] cfg_prev, cfg_now;
        cfg_t        c;
        done_t       d;
        en_q = 1'b0; done_prev = 1'b0; cfg_prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cfg_now = {bus.sd_dma_partial, bus.sd_dma_partial_start, bus.sd_dma_partial_end,
                       bus.sd_dma_start_mid_block, bus.sd_dma_end_mid_block};
            if (rst) begin
                en_q = 1'b0; done_prev = 1'b0; cfg_prev = cfg_now;
                continue;
            end
            if (bus.cmd_start) begin cmd_cyc = cyc; en_rises = 0; busy_seen = 0; end
            if (bus.busy) busy_seen = 1;
            if (bus.sd_dma_en && !en_q) begin
                en_rises++;
                en_cyc = cyc;
                check("en_while_busy", 32'(bus.busy), 32'd1);
                check("cfg_lead", 32'(cfg_prev), 32'(cfg_now));
                check("cfg_avail", 32'(cfg_q.size() != 0), 32'd1);
                if (cfg_q.size() != 0) begin
                    c = cfg_q.pop_front();
                    check("partial", 32'(bus.sd_dma_partial), 32'(c.partial));
                    check("pstart", 32'(bus.sd_dma_partial_start), 32'(c.ps));
                    check("pend", 32'(bus.sd_dma_partial_end), 32'(c.pe));
                    check("start_mid", 32'(bus.sd_dma_start_mid_block), 32'(c.sm));
                    check("end_mid", 32'(bus.sd_dma_end_mid_block), 32'(c.em));
                end
            end
            if (bus.done) begin
                n_done++;
                check("done_pulse", 32'(done_prev), 32'd0);
                check("busy_at_done", 32'(bus.busy), 32'd0);
                check("en_at_done", 32'(bus.sd_dma_en), 32'd0);
                check("done_avail", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    d = done_q.pop_front();
                    if (d.rem >= 0)    check("blk_remain", 32'(bus.blk_remain), 32'(d.rem));
                    check("err", 32'(bus.err), 32'(d.err));
                    if (d.addr >= 0)   check("sram_addr", 32'(bus.sram_addr), 32'(d.addr));
                    check("en_rises", 32'(en_rises), 32'(d.n_en));
                    check("busy_seen", 32'(busy_seen), 32'(d.busy_seen));
                    if (d.lat_cmd >= 0) check("lat_cmd", 32'(cyc - cmd_cyc), 32'(d.lat_cmd));
                    if (d.lat_en >= 0)  check("lat_en", 32'(cyc - en_cyc), 32'(d.lat_en));
                end
            end
            en_q = bus.sd_dma_en;
            done_prev = bus.done;
            cfg_prev = cfg_now;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.cmd_start = 1'b0; bus.cmd_abort = 1'b0; bus.blk_count = '0;
        bus.first_start = '0; bus.last_end = '0; bus.mid_start = 1'b0; bus.mid_end = 1'b0;
        bus.addr_base = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {bus.busy, bus.done, bus.err, bus.sd_dma_en, bus.sd_dma_partial,
                              bus.blk_remain}, 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        rst = 1'b0;

        // three full blocks
        push_cfgs(3, 3, 0, 1024, 1'b0, 1'b0);
        push_done(0, 0, 'h000100 + 1536, 3, 1, -1, -1);
        send_cmd(3, 0, 1024, 1'b0, 1'b0, 'h000100);
        wait_done("wait_full3", 3000);

        // partial first and last block, mid-block end
        push_cfgs(2, 2, 200, 100, 1'b0, 1'b1);
        push_done(0, 0, 'h002000 + 1024, 2, 1, -1, -1);
        send_cmd(2, 200, 100, 1'b0, 1'b1, 'h002000);
        wait_done("wait_partial2", 2000);

        // strobes while idle must not move the address
        @(posedge clk); #1 idle_nxt = 1'b1;
        repeat (5) @(posedge clk);
        #1 idle_nxt = 1'b0;
        check("idle_nextaddr", 32'(bus.sram_addr), 32'h002400);

        // zero-block command
        push_done(0, 0, -1, 0, 0, 1, -1);
        send_cmd(0, 0, 1024, 1'b0, 1'b0, 'h005000);
        wait_done("wait_zero", 20);

        // single block with inverted offsets
        push_done(-1, 1, -1, 0, 0, 1, -1);
        send_cmd(1, 300, 200, 1'b0, 1'b0, 'h006000);
        wait_done("wait_badrange", 20);

        // single block at the top of the address space; error cleared
        push_cfgs(1, 1, 0, 1024, 1'b1, 1'b0);
        push_done(0, 0, 'h000100, 1, 1, -1, -1);
        send_cmd(1, 0, 1024, 1'b1, 1'b0, 'hFFFF00);
        wait_done("wait_wrap", 1000);

        // enable timeout
        dp_stall = 1'b1;
        push_cfgs(2, 1, 0, 1024, 1'b0, 1'b0);
        push_done(2, 1, 'h000010, 1, 1, -1, 15);
        send_cmd(2, 0, 1024, 1'b0, 1'b0, 'h000010);
        wait_done("wait_timeout", 100);
        dp_stall = 1'b0;

        // abort during block 1 transfer
        push_cfgs(5, 2, 4, 8, 1'b0, 1'b0);
        push_done(3, 0, 'h000300 + 1024, 2, 1, -1, -1);
        send_cmd(5, 4, 8, 1'b0, 1'b0, 'h000300);
        for (int i = 0; i < 2000 && en_rises < 2; i++) @(posedge clk);
        check("abort_wait", 32'(en_rises >= 2), 32'd1);
        repeat (10) @(posedge clk);
        #1 bus.cmd_abort = 1'b1;
        @(posedge clk); #1 bus.cmd_abort = 1'b0;
        wait_done("wait_abort", 2000);

        // asynchronous reset while arming
        dp_stall = 1'b1;
        push_cfgs(1, 1, 0, 1024, 1'b0, 1'b0);
        send_cmd(1, 0, 1024, 1'b0, 1'b0, 'h001234);
        for (int i = 0; i < 50 && en_rises < 1; i++) @(posedge clk);
        check("arm_wait", 32'(en_rises), 32'd1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_outputs", {bus.busy, bus.done, bus.err, bus.sd_dma_en, bus.sd_dma_partial,
                               bus.blk_remain}, 32'd0);
        check("arst_addr", 32'(bus.sram_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dp_stall = 1'b0;

        // normal run after reset, short last block
        push_cfgs(2, 2, 0, 512, 1'b0, 1'b0);
        push_done(0, 0, 'h000040 + 1024, 2, 1, -1, -1);
        send_cmd(2, 0, 512, 1'b0, 1'b0, 'h000040);
        wait_done("wait_post_rst", 2000);

        repeat (3) @(posedge clk);
        check("cfg_q_drained", 32'(cfg_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sd_dma_ctrl.md
# sd_dma_ctrl

Multi-block sequencer for the SD DMA nibble datapath. It takes one command (block count, first-block start offset, last-block end offset, SRAM base address) from the MCU register interface. It then issues one SD DMA enable pulse per 512-byte block and drives the partial/mid-block configuration for each block. It also owns the SRAM write-address counter advanced by the datapath's next-address strobe.

## Interface
- EN_TIMEOUT, 15: cycles to wait for SD_DMA_STATUS to rise after SD_DMA_EN rises before flagging an error.
- ADDR_W, 24: SRAM address width.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CMD_START  in  1  one-cycle pulse; starts a command; ignored unless IDLE.
- CMD_ABORT  in  1  one-cycle pulse; stop after the block in flight.
- BLK_COUNT  in  16  blocks to transfer; sampled on CMD_START.
- FIRST_START  in  11  nibble offset (even, 0..1024) where writing begins in block 0.
- LAST_END  in  11  nibble offset (even, 0..1024) where writing ends in the last block.
- MID_START  in  1  first block resumes a block already partially clocked.
- MID_END  in  1  last block stops clocking at LAST_END.
- ADDR_BASE  in  ADDR_W  initial SRAM address; sampled on CMD_START.
- BUSY  out  1  high from CMD_START acceptance until DONE.
- DONE  out  1  one-cycle pulse at command end (normal, abort or error).
- ERR  out  1  sticky error; cleared by next accepted CMD_START.
- BLK_REMAIN  out  16  blocks not yet completed.
- SD_DMA_EN  out  1  enable to datapath; the rising edge starts one block.
- SD_DMA_STATUS  in  1  datapath busy.
- SD_DMA_NEXTADDR  in  1  datapath address-advance strobe.
- SD_DMA_PARTIAL, SD_DMA_PARTIAL_START[10:0], SD_DMA_PARTIAL_END[10:0], SD_DMA_START_MID_BLOCK, SD_DMA_END_MID_BLOCK  out  per-block config; registered; stable from SETUP through end of XFER.
- SRAM_ADDR  out  ADDR_W  current SRAM write address.

## Operation
- Reset values: every output 0, SRAM_ADDR 0, state IDLE. Reset mid-block does not stop the datapath. After reset, firmware must wait for SD_DMA_STATUS low before issuing a new command.
- States:
  - IDLE:
    - On CMD_START with BLK_COUNT=0: DONE pulse, stay IDLE, no enable issued.
    - On CMD_START with BLK_COUNT=1 and FIRST_START > LAST_END: ERR=1, DONE pulse, no enable issued.
    - Otherwise: latch inputs, BLK_REMAIN=BLK_COUNT, SRAM_ADDR=ADDR_BASE, BUSY=1, go to SETUP.
  - SETUP (1 cycle): drive the block config.
    - first = (BLK_REMAIN==BLK_COUNTr); last = (BLK_REMAIN==1).
    - PARTIAL_START = first ? FIRST_START : 0.
    - PARTIAL_END = last ? LAST_END : 1024.
    - PARTIAL = (PARTIAL_START!=0) or (PARTIAL_END!=1024).
    - START_MID_BLOCK = first & MID_START.
    - END_MID_BLOCK = last & MID_END.
    - SD_DMA_EN=0. Go to ARM.
  - ARM: SD_DMA_EN=1; count cycles.
    - When SD_DMA_STATUS is seen high: go to XFER.
    - When the count reaches EN_TIMEOUT: ERR=1, EN=0, DONE, go to IDLE.
  - XFER: SD_DMA_EN=0. Wait for SD_DMA_STATUS low; then decrement BLK_REMAIN.
    - If the decremented value is 0 or an abort is pending: DONE, go to IDLE.
    - Otherwise: go to SETUP.
- CMD_ABORT sets an abort-pending flag, honoured at the next XFER exit. Abort in SETUP or ARM exits after that block. Abort in IDLE is ignored. The datapath cannot be stopped mid-block, so the in-flight block always completes.
- SRAM_ADDR increments by 1 on every SD_DMA_NEXTADDR cycle while BUSY. It wraps modulo 2^ADDR_W. NEXTADDR outside BUSY is ignored.
- CMD_START while BUSY is ignored.

## Timing
- The datapath detects the enable rising edge through a 2-flop synchronizer and registers PARTIAL one cycle earlier. Config is therefore valid one cycle before EN rises, and held until STATUS falls.
- EN stays low at least 2 cycles between blocks (XFER exit plus SETUP), which guarantees a fresh rising edge.
- Latency:
  - CMD_START at edge n → SETUP at n+1 → EN high at n+2.
  - STATUS is expected high by n+5; timeout is measured from the EN rise.
- Block end: STATUS low sampled at edge m → BLK_REMAIN updated at m+1.
  - Next EN rise at m+2, or DONE pulse at m+1.
- DONE and the BUSY fall occur in the same cycle.

## Structure
- Shared package: the state encoding (IDLE, SETUP, ARM, XFER) and the constants BLOCK_NIBBLES=1024 and the default EN_TIMEOUT.
- No sub-module is required. The address counter may be split into sd_dma_addrgen (load, increment, wrap) if reused by the read-side DMA.

## Test plan
- BLK_COUNT=3, FIRST_START=0, LAST_END=1024, datapath model → 3 EN rises with PARTIAL=0 on all; SRAM_ADDR advances by 1536 from ADDR_BASE; one DONE; ERR=0.
- BLK_COUNT=2, FIRST_START=200, LAST_END=100, MID_END=1 → block 0 has PARTIAL=1, START=200, END=1024, END_MID=0; block 1 has PARTIAL=1, START=0, END=100, END_MID=1.
- BLK_COUNT=0 → DONE one cycle after CMD_START, SD_DMA_EN never rises, BUSY stays 0.
- STATUS held low after EN rise → ERR=1 and DONE exactly EN_TIMEOUT cycles after the EN rise; EN returns to 0.
- BLK_COUNT=5, CMD_ABORT during block 1's XFER → exactly 2 EN rises, BLK_REMAIN=3 at DONE.
- RST asserted during ARM with SRAM_ADDR=0x1234 → all outputs 0 asynchronously. A subsequent CMD_START after STATUS is low runs normally.
